ctpuf_challenge_ctrl: RTL and testbench
=======================================

Name: ctpuf_challenge_ctrl

Overview:
Challenge/response controller for the CT-PUF core. It serialises a parallel challenge onto the PUF serial input (T) one bit per clock and waits a settle interval. It then samples the PUF serial output (fnlout) into a parallel response and compares it against an expected response using a Hamming-distance threshold. It sits on the opposite side of the T/fnlout serial pair from the PUF core, inside the top-level user wrapper.

Parameters:
CH_W, 16, challenge length in bits (>=1)
RSP_W, 8, response length in bits (>=1)
SETTLE, 4, idle cycles between last challenge bit and first response sample (>=0)
HD_W, $clog2(RSP_W+1), width of Hamming-distance and threshold fields

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-low reset (0 = reset)
start  in  1  request a challenge/response run; sampled only in IDLE
challenge  in  CH_W  challenge word, latched on accepted start
expected  in  RSP_W  golden response, latched on accepted start
threshold  in  HD_W  max allowed Hamming distance, latched on accepted start
puf_t  out  1  serial challenge bit to PUF T input
puf_out  in  1  serial response bit from PUF fnlout
busy  out  1  high from accepted start through the DONE cycle
done  out  1  one-cycle pulse when result is valid
pass  out  1  1 if hd <= latched threshold; valid from done, held until next done
response  out  RSP_W  captured response, held until next done
hd  out  HD_W  popcount(response XOR expected), held until next done

Behaviour:
- Reset (async assert, sync release): state=IDLE; puf_t, busy, done, pass = 0; response, hd = 0; all counters and shadow registers = 0. Reset mid-run aborts immediately; no done is issued.
- All outputs are registered.
- FSM states: IDLE, SEND, SETTLE, SAMPLE, CMP, DONE.
- IDLE: if start=1 at a rising edge, latch challenge, expected and threshold, then go to SEND with busy=1. Otherwise stay; puf_t=0.
- SEND: exactly CH_W cycles. puf_t = challenge bit, MSB first: bit CH_W-1 in the first SEND cycle, bit 0 in the last.
- SETTLE: exactly SETTLE cycles with puf_t=0. If SETTLE=0 the state is skipped and SEND goes straight to SAMPLE.
- SAMPLE: exactly RSP_W cycles with puf_t=0. At each rising edge in SAMPLE, puf_out is shifted into the response shift register LSB-in, so the first sampled bit ends up in response[RSP_W-1].
- CMP: one cycle. Compute hd = popcount(shift XOR expected_latched) and pass = (hd <= threshold_latched). Register response, hd and pass at the end of CMP.
- DONE: one cycle with done=1 and busy=1. Next state is IDLE.
- Latency: if start is accepted at edge E, done is high in the cycle beginning at edge E + CH_W + SETTLE + RSP_W + 2. With defaults that is E+30.
- start while busy is ignored; no queuing.
- start held high continuously: the next run is accepted on the first IDLE edge after DONE, giving exactly one idle cycle between runs.
- Input changes on challenge, expected or threshold during a run have no effect.
- threshold >= RSP_W always passes. threshold=0 requires an exact match.
- Counters are wide enough for max(CH_W, SETTLE, RSP_W). No wrap-around is permitted within a state.
- puf_out is treated as synchronous to clk; no synchroniser is included.

Decomposition:
- Shared package ctpuf_pkg: FSM state enum, default CH_W/RSP_W/SETTLE constants, HD_W derivation function.
- One sub-module: ctpuf_popcount, a combinational Hamming-weight counter (parameter W, input vector, output count), instantiated for the CMP stage.

Test Plan:
- Reset mid-SEND (reset low for 1 cycle at cycle 5): puf_t=0, busy=0, done never pulses; a fresh start afterwards completes normally.
- Exact match: challenge=16'hA5C3, model returns 8'h3C, expected=8'h3C, threshold=0. Required: puf_t sequence 1010_0101_1100_0011, done at E+30, response=8'h3C, hd=0, pass=1.
- Threshold boundary: model returns 8'h3F vs expected 8'h3C (hd=2). threshold=2 gives pass=1; threshold=1 gives pass=0, hd=2.
- Worst case: response 8'hFF vs expected 8'h00 gives hd=8. threshold=8 gives pass=1; threshold=7 gives pass=0.
- start pulsed during a run and challenge changed mid-run: only one done, result matches the originally latched challenge. start held high gives done pulses 31 cycles apart.
- SETTLE=0 build: done at E+CH_W+RSP_W+2, and the first sample is taken in the cycle after the last SEND cycle.

Source files
------------

// File: rtl/ctpuf_pkg.sv
// Shared definitions for the CT-PUF challenge/response controller:
// FSM state encoding, default geometry and width helpers.
package ctpuf_pkg;

   localparam int CH_W_DEF   = 16;
   localparam int RSP_W_DEF  = 8;
   localparam int SETTLE_DEF = 4;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SEND   = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_SAMPLE = 3'd3;
   localparam logic [2:0] ST_CMP    = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   function automatic int hd_width(input int rsp_w);
      return $clog2(rsp_w + 1);
   endfunction

   // One counter is shared by SEND, SETTLE and SAMPLE, so it must hold the largest phase length.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/ctpuf_popcount.sv
// Combinational Hamming-weight counter used to score response against expected.
module ctpuf_popcount
   import ctpuf_pkg::*;
#(
   parameter int W  = 8,
   parameter int CW = hd_width(W)
) (
   input  logic [W-1:0]  vec_i,
   output logic [CW-1:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < W; i++) begin
         count_o = count_o + CW'(vec_i[i]);
      end
   end

endmodule

// File: rtl/ctpuf_challenge_ctrl.sv
// Challenge/response controller: shifts a challenge out on puf_t MSB first, waits a settle
// interval, shifts the PUF response in from puf_out and grades it by Hamming distance.
module ctpuf_challenge_ctrl
   import ctpuf_pkg::*;
#(
   parameter int CH_W   = CH_W_DEF,
   parameter int RSP_W  = RSP_W_DEF,
   parameter int SETTLE = SETTLE_DEF,
   parameter int HD_W   = hd_width(RSP_W)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CH_W-1:0]  challenge,
   input  logic [RSP_W-1:0] expected,
   input  logic [HD_W-1:0]  threshold,
   output logic             puf_t,
   input  logic             puf_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [RSP_W-1:0] response,
   output logic [HD_W-1:0]  hd
);

   localparam int CNT_W = cnt_width(CH_W, SETTLE, RSP_W);
   localparam logic [CNT_W-1:0] SEND_LAST   = CNT_W'(CH_W - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(RSP_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CH_W-1:0]  chal_q, chal_d;
   logic [RSP_W-1:0] exp_q, exp_d;
   logic [HD_W-1:0]  thr_q, thr_d;
   logic [RSP_W-1:0] shift_q, shift_d;
   logic [RSP_W-1:0] resp_q, resp_d;
   logic [HD_W-1:0]  hd_q, hd_d;
   logic             pass_q, pass_d;
   logic             puf_t_q, puf_t_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [HD_W-1:0]  pc;

   ctpuf_popcount #(.W(RSP_W), .CW(HD_W)) u_popcount (
      .vec_i   (shift_q ^ exp_q),
      .count_o (pc)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      chal_d  = chal_q;
      exp_d   = exp_q;
      thr_d   = thr_q;
      shift_d = shift_q;
      resp_d  = resp_q;
      hd_d    = hd_q;
      pass_d  = pass_q;
      puf_t_d = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // The MSB goes out in the very first SEND cycle, so it is taken straight from the input.
            if (start) begin
               chal_d  = challenge << 1;
               exp_d   = expected;
               thr_d   = threshold;
               puf_t_d = challenge[CH_W-1];
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (cnt_q == SEND_LAST) begin
               cnt_d   = '0;
               state_d = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
            end else begin
               puf_t_d = chal_q[CH_W-1];
               chal_d  = chal_q << 1;
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_SAMPLE: begin
            // LSB-in: the first sampled bit reaches the MSB after RSP_W shifts.
            shift_d = (shift_q << 1) | RSP_W'(puf_out);
            if (cnt_q == SAMPLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_CMP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_CMP: begin
            resp_d  = shift_q;
            hd_d    = pc;
            pass_d  = (pc <= thr_q);
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         chal_q  <= '0;
         exp_q   <= '0;
         thr_q   <= '0;
         shift_q <= '0;
         resp_q  <= '0;
         hd_q    <= '0;
         pass_q  <= 1'b0;
         puf_t_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         chal_q  <= chal_d;
         exp_q   <= exp_d;
         thr_q   <= thr_d;
         shift_q <= shift_d;
         resp_q  <= resp_d;
         hd_q    <= hd_d;
         pass_q  <= pass_d;
         puf_t_q <= puf_t_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign puf_t    = puf_t_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign response = resp_q;
   assign hd       = hd_q;

endmodule

// File: tb/tb_ctpuf_challenge_ctrl.sv
// Randomised scoreboard bench for ctpuf_challenge_ctrl: a default build (SETTLE=4) and a
// SETTLE=0 build, each driven by a cycle-level PUF stand-in and checked by a negedge monitor.
module tb_ctpuf_challenge_ctrl;

   localparam int CH_W  = 16;
   localparam int RSP_W = 8;
   localparam int HD_W  = 4;
   localparam int NI    = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             st_s  [NI];
   logic [CH_W-1:0]  ch_s  [NI];
   logic [RSP_W-1:0] ex_s  [NI];
   logic [HD_W-1:0]  th_s  [NI];
   logic             pin_s [NI];
   logic             pt_s  [NI];
   logic             busy_s[NI];
   logic             done_s[NI];
   logic             pass_s[NI];
   logic [RSP_W-1:0] rsp_s [NI];
   logic [HD_W-1:0]  hd_s  [NI];

   ctpuf_challenge_ctrl u_dut0 (
      .clk(clk), .reset(rst_n), .start(st_s[0]), .challenge(ch_s[0]), .expected(ex_s[0]),
      .threshold(th_s[0]), .puf_t(pt_s[0]), .puf_out(pin_s[0]), .busy(busy_s[0]),
      .done(done_s[0]), .pass(pass_s[0]), .response(rsp_s[0]), .hd(hd_s[0])
   );

   ctpuf_challenge_ctrl #(.SETTLE(0)) u_dut1 (
      .clk(clk), .reset(rst_n), .start(st_s[1]), .challenge(ch_s[1]), .expected(ex_s[1]),
      .threshold(th_s[1]), .puf_t(pt_s[1]), .puf_out(pin_s[1]), .busy(busy_s[1]),
      .done(done_s[1]), .pass(pass_s[1]), .response(rsp_s[1]), .hd(hd_s[1])
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stimulus staged by the test sequence, applied just after the next rising edge.
   logic             rst_g;
   logic             st_g[NI];
   logic [CH_W-1:0]  ch_g[NI];
   logic [RSP_W-1:0] ex_g[NI];
   logic [HD_W-1:0]  th_g[NI];
   logic [RSP_W-1:0] rg_g[NI];

   // Reference model: the accepted run per instance (start presented in cycle run_e).
   bit               run_v  [NI];
   int               run_e  [NI];
   logic [CH_W-1:0]  run_ch [NI];
   logic [RSP_W-1:0] run_rsp[NI];

   typedef struct {
      int               inst;
      int               cyc;
      logic [RSP_W-1:0] rsp;
      logic [HD_W-1:0]  hd;
      logic             pass;
   } res_t;
   res_t sbq[$];

   logic [RSP_W-1:0] l_rsp [NI];
   logic [HD_W-1:0]  l_hd  [NI];
   logic             l_pass[NI];
   int done_cnt [NI];
   int prev_done[NI];
   int last_done[NI];
   int n_cmp = 0;
   int n_bad = 0;

   function automatic int settle_of(input int i);
      return (i == 0) ? 4 : 0;
   endfunction

   function automatic int lat(input int i);
      return CH_W + settle_of(i) + RSP_W + 2;
   endfunction

   function automatic int popc(input logic [RSP_W-1:0] v);
      int n = 0;
      for (int k = 0; k < RSP_W; k++) n += int'(v[k]);
      return n;
   endfunction

   function automatic int pending(input int i);
      int n = 0;
      foreach (sbq[k]) if (sbq[k].inst == i) n++;
      return n;
   endfunction

   task automatic chk(input int i, input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s (dut%0d) cycle %0d: got %0h, want %0h", nm, i, cyc, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      rst_n = rst_g;
      if (!rst_g) begin
         sbq.delete();
         for (int i = 0; i < NI; i++) begin
            run_v[i] = 1'b0; l_rsp[i] = '0; l_hd[i] = '0; l_pass[i] = 1'b0;
         end
      end
      for (int i = 0; i < NI; i++) begin
         int   sb;
         int   h;
         res_t r;
         st_s[i] = st_g[i]; ch_s[i] = ch_g[i]; ex_s[i] = ex_g[i]; th_s[i] = th_g[i];
         if (rst_g && st_g[i] && (!run_v[i] || cyc > run_e[i] + lat(i))) begin
            run_v[i] = 1'b1; run_e[i] = cyc; run_ch[i] = ch_g[i]; run_rsp[i] = rg_g[i];
            h = popc(rg_g[i] ^ ex_g[i]);
            r.inst = i; r.cyc = cyc + lat(i); r.rsp = rg_g[i];
            r.hd = HD_W'(h); r.pass = (h <= int'(th_g[i]));
            sbq.push_back(r);
         end
         // PUF stand-in: response bits MSB first inside the sample window, noise elsewhere.
         sb = run_e[i] + CH_W + settle_of(i) + 1;
         if (run_v[i] && cyc >= sb && cyc < sb + RSP_W) pin_s[i] = run_rsp[i][RSP_W-1-(cyc-sb)];
         else pin_s[i] = 1'($urandom_range(0, 1));
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int   rel;
         int   idx;
         logic ept;
         logic ebusy;
         rel   = cyc - run_e[i];
         ept   = 1'b0;
         ebusy = 1'b0;
         if (run_v[i] && rel >= 1 && rel <= CH_W) ept = run_ch[i][CH_W-rel];
         if (run_v[i] && rel >= 1 && rel <= lat(i)) ebusy = 1'b1;
         chk(i, "puf_t", int'(pt_s[i]), int'(ept));
         chk(i, "busy", int'(busy_s[i]), int'(ebusy));
         if (done_s[i]) begin
            idx = -1;
            foreach (sbq[k]) if (idx < 0 && sbq[k].inst == i) idx = k;
            if (idx < 0) begin
               chk(i, "done_unexpected", 1, 0);
            end else begin
               chk(i, "done_cycle", cyc, sbq[idx].cyc);
               l_rsp[i] = sbq[idx].rsp; l_hd[i] = sbq[idx].hd; l_pass[i] = sbq[idx].pass;
               sbq.delete(idx);
            end
            done_cnt[i]++;
            prev_done[i] = last_done[i];
            last_done[i] = cyc;
         end
         chk(i, "response", int'(rsp_s[i]), int'(l_rsp[i]));
         chk(i, "hd", int'(hd_s[i]), int'(l_hd[i]));
         chk(i, "pass", int'(pass_s[i]), int'(l_pass[i]));
      end
   end

   task automatic start_run(input int i, input logic [CH_W-1:0] ch, input logic [RSP_W-1:0] ex,
                            input logic [HD_W-1:0] th, input logic [RSP_W-1:0] rsp);
      st_g[i] = 1'b1; ch_g[i] = ch; ex_g[i] = ex; th_g[i] = th; rg_g[i] = rsp;
      tick();
      st_g[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int n = 0;
      while (pending(i) > 0 && n < 100) begin
         tick();
         n++;
      end
      chk(i, "run_completes", pending(i), 0);
      tick();
      tick();
   endtask

   int               d0;
   int               ri;
   logic [RSP_W-1:0] rr;
   logic [RSP_W-1:0] re;

   initial begin
      rst_g = 1'b0;
      for (int i = 0; i < NI; i++) begin
         st_g[i] = 1'b0; ch_g[i] = '0; ex_g[i] = '0; th_g[i] = '0; rg_g[i] = '0;
         st_s[i] = 1'b0; ch_s[i] = '0; ex_s[i] = '0; th_s[i] = '0; pin_s[i] = 1'b0;
         run_v[i] = 1'b0; run_e[i] = 0; run_ch[i] = '0; run_rsp[i] = '0;
         l_rsp[i] = '0; l_hd[i] = '0; l_pass[i] = 1'b0;
         done_cnt[i] = 0; prev_done[i] = 0; last_done[i] = 0;
      end
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      rst_g = 1'b1;
      repeat (2) tick();

      // Abort in the middle of SEND, then a clean run.
      start_run(0, CH_W'($urandom), RSP_W'($urandom), 4'd3, RSP_W'($urandom));
      repeat (4) tick();
      rst_g = 1'b0;
      tick();
      rst_g = 1'b1;
      repeat (40) tick();
      chk(0, "done_after_abort", done_cnt[0], 0);
      start_run(0, 16'h5A0F, 8'h81, 4'd1, 8'h80);
      wait_idle(0);

      // Exact match, threshold boundaries and worst case.
      start_run(0, 16'hA5C3, 8'h3C, 4'd0, 8'h3C); wait_idle(0);
      start_run(0, 16'hA5C3, 8'h3C, 4'd2, 8'h3F); wait_idle(0);
      start_run(0, 16'hA5C3, 8'h3C, 4'd1, 8'h3F); wait_idle(0);
      start_run(0, 16'h0F0F, 8'h00, 4'd8, 8'hFF); wait_idle(0);
      start_run(0, 16'h0F0F, 8'h00, 4'd7, 8'hFF); wait_idle(0);
      start_run(0, 16'hFFFF, 8'h00, 4'd15, 8'hFF); wait_idle(0);

      // start and inputs disturbed while busy.
      d0 = done_cnt[0];
      start_run(0, 16'h1234, 8'h55, 4'd3, 8'h5A);
      repeat (6) tick();
      st_g[0] = 1'b1; ch_g[0] = 16'hFFFF; ex_g[0] = 8'hAA; th_g[0] = 4'd0; rg_g[0] = 8'h00;
      repeat (5) tick();
      st_g[0] = 1'b0; ch_g[0] = 16'h0000;
      wait_idle(0);
      chk(0, "single_done", done_cnt[0] - d0, 1);

      // start held high: back-to-back runs.
      d0 = done_cnt[0];
      st_g[0] = 1'b1;
      repeat (70) begin
         ch_g[0] = CH_W'($urandom); ex_g[0] = RSP_W'($urandom);
         th_g[0] = HD_W'($urandom_range(0, 15)); rg_g[0] = RSP_W'($urandom);
         tick();
      end
      st_g[0] = 1'b0;
      wait_idle(0);
      chk(0, "held_runs", done_cnt[0] - d0, 3);
      chk(0, "held_gap", last_done[0] - prev_done[0], 31);

      // SETTLE=0 build.
      start_run(1, 16'hA5C3, 8'h3C, 4'd0, 8'h3C); wait_idle(1);
      start_run(1, 16'hA5C3, 8'h3C, 4'd1, 8'h3F); wait_idle(1);

      // Both builds started together.
      st_g[0] = 1'b1; ch_g[0] = 16'hC001; ex_g[0] = 8'hF0; th_g[0] = 4'd4; rg_g[0] = 8'hE1;
      st_g[1] = 1'b1; ch_g[1] = 16'h8001; ex_g[1] = 8'h0F; th_g[1] = 4'd2; rg_g[1] = 8'h1E;
      tick();
      st_g[0] = 1'b0; st_g[1] = 1'b0;
      wait_idle(0);
      wait_idle(1);

      // Random runs with responses near and far from the expected word.
      repeat (16) begin
         ri = $urandom_range(0, 1);
         rr = RSP_W'($urandom);
         re = rr ^ (RSP_W'($urandom) & RSP_W'($urandom));
         start_run(ri, CH_W'($urandom), re, HD_W'($urandom_range(0, 15)), rr);
         repeat ($urandom_range(0, 3)) tick();
         wait_idle(ri);
      end

      chk(0, "scoreboard_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
